// File: rtl/or16_result_checker.sv
// or16_result_checker: checks a stream of (a, b, y) vectors from a 16-bit OR
// stage. A run is started with a vector count, and every accepted vector is
// compared against a|b. The block counts mismatches (saturating) and keeps the
// index and y value of the first mismatch of the run.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, num_vectors   run request and vector count (sampled on accept)
//   in_valid, a, b, y    vector under check
//   in_ready             vector accepted this cycle (high only in RUN)
//   busy, done, pass     run in progress / run complete / complete and clean
//   err_count            mismatches in current or last run (saturating)
//   first_err_idx        index of the first mismatching vector
//   first_err_y          y of the first mismatching vector
module or16_result_checker #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_y
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] num_q, num_next;
  logic [CNT_W-1:0] vec_idx, vec_idx_next;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] first_idx_next;
  logic [WIDTH-1:0] first_y_next;
  logic             first_seen, first_seen_next;
  logic             mismatch;

  assign mismatch = (y != (a | b));

  // Next-state and datapath update.
  always_comb begin
    state_next      = state;
    num_next        = num_q;
    vec_idx_next    = vec_idx;
    err_next        = err_count;
    first_idx_next  = first_err_idx;
    first_y_next    = first_err_y;
    first_seen_next = first_seen;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          num_next        = num_vectors;
          vec_idx_next    = '0;
          err_next        = '0;
          first_idx_next  = '0;
          first_y_next    = '0;
          first_seen_next = 1'b0;
          state_next      = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (mismatch) begin
            if (err_count != CNT_MAX) begin
              err_next = err_count + CNT_W'(1);
            end
            if (!first_seen) begin
              first_seen_next = 1'b1;
              first_idx_next  = vec_idx;
              first_y_next    = y;
            end
          end
          vec_idx_next = vec_idx + CNT_W'(1);
          // num_q is nonzero in RUN, so num_q-1 is the last index.
          if (vec_idx == num_q - CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers; status flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_q         <= '0;
      vec_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_y   <= '0;
      first_seen    <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state         <= state_next;
      num_q         <= num_next;
      vec_idx       <= vec_idx_next;
      err_count     <= err_next;
      first_err_idx <= first_idx_next;
      first_err_y   <= first_y_next;
      first_seen    <= first_seen_next;
      in_ready      <= (state_next == RUN);
      busy          <= (state_next == RUN);
      done          <= (state_next == DONE);
      pass          <= (state_next == DONE) && (err_next == '0);
    end
  end

endmodule

// File: tb/tb_or16_result_checker.sv
// Bench for or16_result_checker: directed vectors, a run-level model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_or16_result_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic        in_valid;
  logic [15:0] a, b, y;
  logic        in_ready, busy, done, pass;
  logic [15:0] err_count, first_err_idx, first_err_y;

  int checks;
  int errors;

  or16_result_checker #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .a(a), .b(b), .y(y),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_y(first_err_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run is active or finished; mismatches are counted as
  // integers capped at 65535 and the first one is remembered.
  bit m_run, m_done, m_first;
  int m_n, m_idx, m_err, m_fidx, m_fy, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_done <= 0; m_first <= 0;
      m_n <= 0; m_idx <= 0; m_err <= 0; m_fidx <= 0; m_fy <= 0;
    end else if (m_run) begin
      if (in_valid) begin
        m_acc <= m_acc + 1;
        if (y !== (a | b)) begin
          if (m_err < 65535) m_err <= m_err + 1;
          if (!m_first) begin
            m_first <= 1;
            m_fidx  <= m_idx;
            m_fy    <= int'(y);
          end
        end
        m_idx <= m_idx + 1;
        if (m_idx + 1 == m_n) begin
          m_run  <= 0;
          m_done <= 1;
        end
      end
    end else if (start) begin
      m_acc <= 0; m_err <= 0; m_fidx <= 0; m_fy <= 0; m_first <= 0;
      m_idx <= 0; m_n <= int'(num_vectors);
      m_run  <= (num_vectors != 0);
      m_done <= (num_vectors == 0);
    end
  end

  // Compare DUT against model every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_run));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    if (m_done) check("pass", 32'(pass), 32'(m_err == 0));
    check("err_count", 32'(err_count), 32'(m_err));
    check("first_err_idx", 32'(first_err_idx), 32'(m_fidx));
    check("first_err_y", 32'(first_err_y), 32'(m_fy));
  end

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [15:0] ta,
                      input logic [15:0] tb_, input logic [15:0] ty);
    in_valid = v; a = ta; b = tb_; y = ty;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; num_vectors = '0;
    in_valid = 1'b0; a = '0; b = '0; y = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);

    // Start on the first edge after release, with zero vectors.
    #2 rst_n = 1'b1;
    do_start(16'd0);
    check("zero_first_done", 32'(done), 32'd1);
    check("zero_first_pass", 32'(pass), 32'd1);

    // Clean run of four vectors.
    do_start(16'd4);
    send(1, 16'h0000, 16'h0000, 16'h0000);
    send(1, 16'h00FF, 16'hFF00, 16'hFFFF);
    send(1, 16'h1234, 16'h0001, 16'h1235);
    check("clean_not_done", 32'(done), 32'd0);
    send(1, 16'hFFFF, 16'h0000, 16'hFFFF);
    check("clean_done", 32'(done), 32'd1);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_acc", 32'(m_acc), 32'd4);

    // Injected faults on vectors 1 and 2.
    do_start(16'd3);
    send(1, 16'h0000, 16'h0000, 16'h0000);
    send(1, 16'h000F, 16'h00F0, 16'h00F7);
    send(1, 16'h0001, 16'h0000, 16'h0000);
    check("fault_done", 32'(done), 32'd1);
    check("fault_err", 32'(err_count), 32'd2);
    check("fault_idx", 32'(first_err_idx), 32'd1);
    check("fault_y", 32'(first_err_y), 32'h00F7);
    check("fault_pass", 32'(pass), 32'd0);

    // Stalls: in_valid 1,0,0,1 for two vectors.
    do_start(16'd2);
    send(1, 16'h0101, 16'h1010, 16'h1111);
    send(0, 16'hDEAD, 16'hBEEF, 16'h0000);
    send(0, 16'hDEAD, 16'hBEEF, 16'h0000);
    check("stall_not_done", 32'(done), 32'd0);
    send(1, 16'h8000, 16'h0001, 16'h8001);
    check("stall_done", 32'(done), 32'd1);
    check("stall_acc", 32'(m_acc), 32'd2);

    // Zero-length run from DONE; vectors offered are not taken.
    do_start(16'd0);
    send(1, 16'h0001, 16'h0002, 16'h0000);
    check("zero_done", 32'(done), 32'd1);
    check("zero_pass", 32'(pass), 32'd1);
    check("zero_acc", 32'(m_acc), 32'd0);

    // Start during RUN is ignored.
    do_start(16'd3);
    send(1, 16'h0F00, 16'h00F0, 16'h0FF0);
    start = 1'b1; num_vectors = 16'd5;
    send(1, 16'h0003, 16'h0004, 16'h0007);
    start = 1'b0;
    send(1, 16'h0010, 16'h0020, 16'h0030);
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_acc", 32'(m_acc), 32'd3);

    // Reset after two of four vectors (both wrong).
    do_start(16'd4);
    send(1, 16'h0001, 16'h0000, 16'h0000);
    send(1, 16'h0002, 16'h0000, 16'h0000);
    check("pre_rst_err", 32'(err_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err_count), 32'd0);
    check("midrst_idx", 32'(first_err_idx), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_start(16'd4);
    send(1, 16'h0001, 16'h0002, 16'h0003);
    send(1, 16'h0004, 16'h0008, 16'h000C);
    send(1, 16'h0010, 16'h0020, 16'h0030);
    check("rerun_not_done", 32'(done), 32'd0);
    send(1, 16'h0040, 16'h0080, 16'h00C0);
    check("rerun_done", 32'(done), 32'd1);
    check("rerun_pass", 32'(pass), 32'd1);

    // Saturation: 65535 vectors all wrong, then extra vectors in DONE.
    do_start(16'hFFFF);
    for (int i = 0; i < 65535; i++) send(1, 16'(i), 16'h0000, ~16'(i));
    check("sat_done", 32'(done), 32'd1);
    check("sat_err", 32'(err_count), 32'h0000FFFF);
    check("sat_idx", 32'(first_err_idx), 32'd0);
    check("sat_y", 32'(first_err_y), 32'h0000FFFF);
    check("sat_pass", 32'(pass), 32'd0);
    for (int i = 0; i < 4; i++) send(1, 16'h0001, 16'h0000, 16'h0000);
    check("sat_hold_err", 32'(err_count), 32'h0000FFFF);
    check("sat_hold_done", 32'(done), 32'd1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or16_result_checker.md
OR16_RESULT_CHECKER -- requirements
Module: or16_result_checker

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width of the 16-bit OR stage under check.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle request to begin a check run.
REQ-005 Port: num_vectors  input  16  number of vectors in the run; sampled only when start is accepted.
REQ-006 Port: in_valid  input  1  a, b and y carry a vector this cycle.
REQ-007 Port: a  input  WIDTH  operand A driven into the OR stage.
REQ-008 Port: b  input  WIDTH  operand B driven into the OR stage.
REQ-009 Port: y  input  WIDTH  result produced by the OR stage for a, b.
REQ-010 Port: in_ready  output  1  checker accepts a vector this cycle.
REQ-011 Port: busy  output  1  run in progress.
REQ-012 Port: done  output  1  run complete; held until the next start or reset.
REQ-013 Port: pass  output  1  run complete with zero mismatches; valid only while done=1.
REQ-014 Port: err_count  output  16  mismatches in the current or last run; saturating.
REQ-015 Port: first_err_idx  output  16  index of the first mismatching vector.
REQ-016 Port: first_err_y  output  WIDTH  y value of the first mismatching vector.

Function
REQ-017 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-018 From IDLE or DONE, a start with num_vectors=0 SHALL go to DONE next cycle with err_count=0 and pass=1.
REQ-019 From IDLE or DONE, a start with num_vectors>0 SHALL go to RUN; it SHALL latch num_vectors and clear vec_idx, err_count, first_err_idx, first_err_y and the first-error flag.
REQ-020 A start while in RUN SHALL be ignored.
REQ-021 in_ready SHALL equal 1 exactly in RUN; busy SHALL equal 1 exactly in RUN; done SHALL equal 1 exactly in DONE.
REQ-022 A vector SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_valid=0 in RUN SHALL stall with no state change.
REQ-023 The expected value SHALL be a|b (bitwise, WIDTH bits); a mismatch SHALL mean y differs from a|b in any bit.
REQ-024 On an accepted mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-025 On the first accepted mismatch of a run only, first_err_idx SHALL take vec_idx and first_err_y SHALL take y.
REQ-026 vec_idx SHALL increment by 1 on each accepted vector.
REQ-027 Acceptance of vector num_vectors-1 SHALL move the FSM to DONE; done SHALL be 1 in the following cycle, with err_count already including that vector.
REQ-028 pass SHALL equal 1 in DONE when err_count=0, and 0 otherwise.
REQ-029 All outputs SHALL be registered or decoded directly from state; there SHALL be no combinational path from a, b or y to any output.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously enter IDLE, including mid-run, and discard the run.
REQ-031 During reset, in_ready, busy, done and pass SHALL be 0.
REQ-032 During reset, err_count, first_err_idx, first_err_y and vec_idx SHALL be 0.
REQ-033 Release of rst_n SHALL be sampled synchronously; a start on the first edge after release SHALL be honoured.

Verification
REQ-034 Clean run: start, num_vectors=4; vectors (0000,0000,0000), (00FF,FF00,FFFF), (1234,0001,1235), (FFFF,0000,FFFF) -> done=1 one cycle after 4th accept, pass=1, err_count=0.
REQ-035 Injected fault: num_vectors=3; vector 1 = a=000F, b=00F0, y=00F7 (expected 00FF); vector 2 y=0000 for a=0001, b=0000 -> err_count=2, first_err_idx=1, first_err_y=00F7, pass=0.
REQ-036 Stall and boundary: num_vectors=2, in_valid toggled 1,0,0,1 -> exactly 2 accepts, done asserted after 4th cycle; num_vectors=0 -> done and pass next cycle, no accepts.
REQ-037 Start during RUN with num_vectors=5 while running 3 -> ignored, run ends after 3 accepts.
REQ-038 Reset mid-run: assert rst_n=0 after 2 of 4 vectors -> immediately in_ready=0, err_count=0, state IDLE; new start runs from vec_idx=0.
REQ-039 Saturation: num_vectors=16'hFFFF with every y wrong, then one extra run without restart -> err_count=FFFF, no wrap.
